// File: rtl/cpu_pkg.sv
// Shared encodings for the instruction controller: FSM states, ISA opcode/op codes, write-back selects.
package cpu_pkg;

  localparam logic [2:0] ST_WAIT   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_GET_A  = 3'd2;
  localparam logic [2:0] ST_GET_B  = 3'd3;
  localparam logic [2:0] ST_ALU    = 3'd4;
  localparam logic [2:0] ST_WR_REG = 3'd5;
  localparam logic [2:0] ST_WR_IMM = 3'd6;

  typedef enum logic [2:0] {
    S_WAIT   = ST_WAIT,
    S_DECODE = ST_DECODE,
    S_GET_A  = ST_GET_A,
    S_GET_B  = ST_GET_B,
    S_ALU    = ST_ALU,
    S_WR_REG = ST_WR_REG,
    S_WR_IMM = ST_WR_IMM
  } state_e;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

endpackage

// File: rtl/cpu_controller_instr_dec.sv
// Combinational instruction decode: field extraction, sign extension, and instruction class flags.
module instr_dec
  import cpu_pkg::*;
(
  input  logic [15:0] ir_i,
  output logic [2:0]  rn_o,
  output logic [2:0]  rd_o,
  output logic [2:0]  rm_o,
  output logic [1:0]  op_o,
  output logic [1:0]  sh_o,
  output logic [15:0] sximm8_o,
  output logic [15:0] sximm5_o,
  output logic        is_mov_imm_o,
  output logic        is_mov_reg_o,
  output logic        is_mvn_o,
  output logic        is_cmp_o,
  output logic        legal_o
);

  logic [2:0] opcode;
  logic       is_alu;

  assign opcode   = ir_i[15:13];
  assign op_o     = ir_i[12:11];
  assign rn_o     = ir_i[10:8];
  assign rd_o     = ir_i[7:5];
  assign sh_o     = ir_i[4:3];
  assign rm_o     = ir_i[2:0];
  assign sximm8_o = {{8{ir_i[7]}}, ir_i[7:0]};
  assign sximm5_o = {{11{ir_i[4]}}, ir_i[4:0]};

  // Every op under the ALU opcode is legal; only two of the four MOV ops are.
  assign is_alu       = (opcode == OPC_ALU);
  assign is_mov_imm_o = (opcode == OPC_MOV) && (op_o == OP_MOV_IMM);
  assign is_mov_reg_o = (opcode == OPC_MOV) && (op_o == OP_MOV_REG);
  assign is_mvn_o     = is_alu && (op_o == OP_MVN);
  assign is_cmp_o     = is_alu && (op_o == OP_CMP);
  assign legal_o      = is_alu || is_mov_imm_o || is_mov_reg_o;

endmodule

// File: rtl/cpu_controller.sv
// Instruction register plus Moore FSM sequencing the register-file/ALU datapath, one instruction per s request.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int IW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s,
  input  logic          load,
  input  logic [IW-1:0] in,
  output logic          w,
  output logic [RW-1:0] readnum,
  output logic [RW-1:0] writenum,
  output logic          write,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    vsel,
  output logic [1:0]    shift,
  output logic [1:0]    ALUop,
  output logic [15:0]   sximm8,
  output logic [15:0]   sximm5,
  output logic [2:0]    dbg_state
);

  state_e        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;

  logic [2:0] rn, rd, rm;
  logic [1:0] op, sh;
  logic       is_mov_imm, is_mov_reg, is_mvn, is_cmp, legal;

  instr_dec u_dec (
    .ir_i         (ir_q),
    .rn_o         (rn),
    .rd_o         (rd),
    .rm_o         (rm),
    .op_o         (op),
    .sh_o         (sh),
    .sximm8_o     (sximm8),
    .sximm5_o     (sximm5),
    .is_mov_imm_o (is_mov_imm),
    .is_mov_reg_o (is_mov_reg),
    .is_mvn_o     (is_mvn),
    .is_cmp_o     (is_cmp),
    .legal_o      (legal)
  );

  assign dbg_state = state_q;
  assign shift     = sh;

  // IR only accepts a new word while idle, so the instruction in flight is never disturbed.
  always_comb begin
    ir_d = ir_q;
    if (state_q == S_WAIT && load) ir_d = in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    w        = 1'b0;
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = VSEL_C;
    ALUop    = op;
    case (state_q)
      S_WAIT: begin
        w = 1'b1;
        if (s) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!legal)                    state_d = S_WAIT;
        else if (is_mov_imm)           state_d = S_WR_IMM;
        else if (is_mov_reg || is_mvn) state_d = S_GET_B;
        else                           state_d = S_GET_A;
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = S_GET_B;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
        state_d = S_ALU;
      end
      S_ALU: begin
        // Single-operand instructions zero the A side so the ALU passes/inverts B.
        asel = is_mov_reg || is_mvn;
        if (is_mov_reg) ALUop = 2'b00;
        if (is_cmp) begin
          loads   = 1'b1;
          state_d = S_WAIT;
        end else begin
          loadc   = 1'b1;
          state_d = S_WR_REG;
        end
      end
      S_WR_REG: begin
        writenum = rd;
        vsel     = VSEL_C;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      S_WR_IMM: begin
        writenum = rn;
        vsel     = VSEL_IMM8;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: per-instruction control traces from a vector table plus corner-case sequences.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset, s, load;
  logic [15:0] in_r;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum, dbg_state;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8, sximm5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in_r),
    .w(w), .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(ALUop),
    .sximm8(sximm8), .sximm5(sximm5), .dbg_state(dbg_state)
  );

  // Control bundle: {readnum, writenum, write, loada, loadb, loadc, loads, asel, bsel, vsel, w}
  logic [15:0] act_ctl;
  assign act_ctl = {readnum, writenum, write, loada, loadb, loadc, loads, asel, bsel, vsel, w};

  function automatic logic [15:0] mk(input logic [2:0] rdn, input logic [2:0] wrn,
                                     input logic wr, input logic la, input logic lb,
                                     input logic lc, input logic ls, input logic as,
                                     input logic bs, input logic [1:0] vs, input logic ww);
    return {rdn, wrn, wr, la, lb, lc, ls, as, bs, vs, ww};
  endfunction

  typedef struct {
    logic [15:0]      instr;
    int               lat;
    logic [1:0]       op;
    logic [1:0]       sh;
    logic [15:0]      sx8;
    logic [15:0]      sx5;
    logic [5:0][15:0] steps;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; s = 1'b0; load = 1'b0; in_r = '0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic run_vec(input int i);
    @(negedge clk);
    in_r = vecs[i].instr; load = 1'b1; s = 1'b1;
    @(posedge clk); #1;
    s = 1'b0; load = 1'b0;
    check16($sformatf("v%0d op", i),     {14'd0, ALUop}, {14'd0, vecs[i].op});
    check16($sformatf("v%0d shift", i),  {14'd0, shift}, {14'd0, vecs[i].sh});
    check16($sformatf("v%0d sximm8", i), sximm8, vecs[i].sx8);
    check16($sformatf("v%0d sximm5", i), sximm5, vecs[i].sx5);
    for (int k = 0; k < vecs[i].lat; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      check16($sformatf("v%0d step%0d ctl", i, k), act_ctl, vecs[i].steps[k]);
    end
  endtask

  task automatic set_vec(input int i, input logic [15:0] instr, input int lat,
                         input logic [1:0] op, input logic [1:0] sh,
                         input logic [15:0] sx8, input logic [15:0] sx5);
    vecs[i].instr = instr; vecs[i].lat = lat; vecs[i].op = op; vecs[i].sh = sh;
    vecs[i].sx8 = sx8; vecs[i].sx5 = sx5; vecs[i].steps = '0;
  endtask

  logic [15:0] wt;
  int wr_seen;

  initial begin
    reset = 1'b1; s = 1'b0; load = 1'b0; in_r = '0;
    wt = mk(3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1);

    // MOV R0,#7
    set_vec(0, 16'hD007, 3, 2'b10, 2'b00, 16'h0007, 16'h0007);
    vecs[0].steps[1] = mk(3'd0, 3'd0, 1, 0, 0, 0, 0, 0, 0, 2'b10, 0);
    vecs[0].steps[2] = wt;
    // MOV R1,R0,LSL#1
    set_vec(1, 16'hC028, 5, 2'b00, 2'b01, 16'h0028, 16'h0008);
    vecs[1].steps[1] = mk(3'd0, 3'd0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0);
    vecs[1].steps[2] = mk(3'd0, 3'd0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0);
    vecs[1].steps[3] = mk(3'd0, 3'd1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    vecs[1].steps[4] = wt;
    // ADD R2,R1,R0
    set_vec(2, 16'hA140, 6, 2'b00, 2'b00, 16'h0040, 16'h0000);
    vecs[2].steps[1] = mk(3'd1, 3'd0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0);
    vecs[2].steps[2] = mk(3'd0, 3'd0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0);
    vecs[2].steps[3] = mk(3'd0, 3'd0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0);
    vecs[2].steps[4] = mk(3'd0, 3'd2, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    vecs[2].steps[5] = wt;
    // CMP R0,R1
    set_vec(3, 16'hA801, 5, 2'b01, 2'b00, 16'h0001, 16'h0001);
    vecs[3].steps[1] = mk(3'd0, 3'd0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0);
    vecs[3].steps[2] = mk(3'd1, 3'd0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0);
    vecs[3].steps[3] = mk(3'd0, 3'd0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0);
    vecs[3].steps[4] = wt;
    // Illegal 000/00
    set_vec(4, 16'h0000, 2, 2'b00, 2'b00, 16'h0000, 16'h0000);
    vecs[4].steps[1] = wt;
    // MVN R3,R2
    set_vec(5, 16'hB862, 5, 2'b11, 2'b00, 16'h0062, 16'h0002);
    vecs[5].steps[1] = mk(3'd2, 3'd0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0);
    vecs[5].steps[2] = mk(3'd0, 3'd0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0);
    vecs[5].steps[3] = mk(3'd0, 3'd3, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    vecs[5].steps[4] = wt;
    // AND R5,R4,R6,LSR
    set_vec(6, 16'hB4B6, 6, 2'b10, 2'b10, 16'hFFB6, 16'hFFF6);
    vecs[6].steps[1] = mk(3'd4, 3'd0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0);
    vecs[6].steps[2] = mk(3'd6, 3'd0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0);
    vecs[6].steps[3] = mk(3'd0, 3'd0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0);
    vecs[6].steps[4] = mk(3'd0, 3'd5, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    vecs[6].steps[5] = wt;
    // Illegal 110/01
    set_vec(7, 16'hC800, 2, 2'b01, 2'b00, 16'h0000, 16'h0000);
    vecs[7].steps[1] = wt;
    // MOV R5,#-16
    set_vec(8, 16'hD5F0, 3, 2'b10, 2'b10, 16'hFFF0, 16'hFFF0);
    vecs[8].steps[1] = mk(3'd0, 3'd5, 1, 0, 0, 0, 0, 0, 0, 2'b10, 0);
    vecs[8].steps[2] = wt;
    // Illegal opcode 111
    set_vec(9, 16'hE000, 2, 2'b00, 2'b00, 16'h0000, 16'h0000);
    vecs[9].steps[1] = wt;

    // Reset state
    do_reset();
    check16("reset ctl", act_ctl, wt);
    check16("reset state", {13'd0, dbg_state}, 16'd0);
    check16("reset sximm8", sximm8, 16'h0000);
    check16("reset sximm5", sximm5, 16'h0000);

    for (int i = 0; i < NV; i++) run_vec(i);

    // load is ignored outside WAIT: attempt to overwrite IR during GET_B of an ADD
    @(negedge clk);
    in_r = 16'hA140; load = 1'b1; s = 1'b1;
    @(posedge clk); #1; s = 1'b0; load = 1'b0;   // DECODE
    @(posedge clk); #1;                           // GET_A
    @(posedge clk); #1;                           // GET_B
    in_r = 16'hFFFF; load = 1'b1;
    @(posedge clk); #1;                           // ALU
    load = 1'b0;
    check16("ir protect sximm8", sximm8, 16'h0040);
    check16("ir protect alu ctl", act_ctl, mk(3'd0, 3'd0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0));
    @(posedge clk); #1;                           // WR_REG
    check16("ir protect wr_reg", act_ctl, mk(3'd0, 3'd2, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    @(posedge clk); #1;
    check16("ir protect back to wait", act_ctl, wt);

    // s held high re-launches the same IR right after reaching WAIT
    @(negedge clk);
    in_r = 16'hD007; load = 1'b1; s = 1'b1;
    @(posedge clk); #1; load = 1'b0;              // DECODE
    @(posedge clk); #1;                           // WR_IMM
    @(posedge clk); #1;                           // WAIT
    check16("relaunch wait", act_ctl, wt);
    @(posedge clk); #1;                           // DECODE again
    check16("relaunch decode", act_ctl, 16'h0000);
    @(posedge clk); #1;
    s = 1'b0;
    check16("relaunch wr_imm", act_ctl, mk(3'd0, 3'd0, 1, 0, 0, 0, 0, 0, 0, 2'b10, 0));
    @(posedge clk); #1;
    check16("relaunch done", act_ctl, wt);

    // Reset during ALU of an ADD: write never asserted, IR cleared
    @(negedge clk);
    in_r = 16'hA140; load = 1'b1; s = 1'b1;
    wr_seen = 0;
    @(posedge clk); #1; s = 1'b0; load = 1'b0;   // DECODE
    if (write) wr_seen++;
    @(posedge clk); #1;                           // GET_A
    if (write) wr_seen++;
    @(posedge clk); #1;                           // GET_B
    if (write) wr_seen++;
    @(posedge clk); #1;                           // ALU
    if (write) wr_seen++;
    reset = 1'b1; s = 1'b1; load = 1'b1; in_r = 16'h5555;
    @(posedge clk); #1;
    if (write) wr_seen++;
    reset = 1'b0; s = 1'b0; load = 1'b0;
    check16("reset mid ctl", act_ctl, wt);
    check16("reset mid state", {13'd0, dbg_state}, 16'd0);
    check16("reset mid sximm8", sximm8, 16'h0000);
    check16("reset mid write seen", wr_seen[15:0], 16'd0);
    @(posedge clk); #1;
    check16("reset mid stays idle", act_ctl, wt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
